// File: rtl/fft_pkg.sv
// Shared constants and helpers for the streaming 64-point FFT datapath.
package fft_pkg;

    localparam int FFT_N = 64;

    typedef enum logic {
        FILL = 1'b0,
        BFLY = 1'b1
    } stage_e;

    function automatic int data_width(input int int_bits, input int fract_bits);
        return int_bits + fract_bits;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Enable-gated DEPTH-entry delay: dout is the word written DEPTH enables ago.
module sdf_delay_line
    import fft_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 1) begin : g_reg
            logic [WIDTH-1:0] data_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q <= '0;
                end else if (en) begin
                    data_q <= din;
                end
            end

            assign dout = data_q;
        end else begin : g_ring
            localparam int PW = clog2(DEPTH);

            logic [DEPTH-1:0][WIDTH-1:0] mem_q;
            logic [PW-1:0]               ptr_q;

            // Read-before-write at the same slot gives exactly DEPTH samples of delay.
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_q <= '0;
                    ptr_q <= '0;
                end else if (en) begin
                    mem_q[ptr_q] <= din;
                    ptr_q        <= (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
                end
            end

            assign dout = mem_q[ptr_q];
        end
    endgenerate

endmodule

// File: rtl/sdf_butterfly_stage.sv
// Radix-2 DIF single-path delay-feedback butterfly; one output per accepted sample.
module sdf_butterfly_stage
    import fft_pkg::*;
#(
    parameter int  INTEGER_SIZE = 8,
    parameter int  FRACT_SIZE   = 8,
    parameter int  DELAY        = 32,
    parameter int  TW_W         = 5,
    parameter int  TW_STRIDE    = 1,
    parameter int  SCALE        = 1,
    localparam int DATA_WIDTH   = data_width(INTEGER_SIZE, FRACT_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_r,
    input  logic [DATA_WIDTH-1:0] in_i,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_r,
    output logic [DATA_WIDTH-1:0] out_i,
    output logic [TW_W-1:0]       tw_idx,
    output logic                  out_sof
);

    localparam int DW = DATA_WIDTH;
    localparam int CW = clog2(2 * DELAY);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic            primed_q, primed_d;
    logic            out_valid_q, out_valid_d;
    logic            out_sof_q, out_sof_d;
    logic [DW-1:0]   out_r_q, out_r_d;
    logic [DW-1:0]   out_i_q, out_i_d;
    logic [TW_W-1:0] tw_q, tw_d;

    logic [2*DW-1:0] dl_din, dl_dout;
    logic [DW-1:0]   d_r, d_i;
    logic [DW:0]     sum_r, sum_i, dif_r, dif_i;
    logic [TW_W-1:0] tw_fill;
    stage_e          stage;

    function automatic logic [DW-1:0] rescale(input logic [DW:0] s);
        if (SCALE != 0) return s[DW:1];
        else            return s[DW-1:0];
    endfunction

    sdf_delay_line #(
        .WIDTH (2 * DW),
        .DEPTH (DELAY)
    ) u_dl (
        .clk  (clk),
        .rst  (rst),
        .en   (in_valid),
        .din  (dl_din),
        .dout (dl_dout)
    );

    assign d_r = dl_dout[2*DW-1:DW];
    assign d_i = dl_dout[DW-1:0];

    // Block length is a power of two, so the counter MSB alone marks the second half.
    assign stage = cnt_q[CW-1] ? BFLY : FILL;

    assign sum_r = {d_r[DW-1], d_r} + {in_r[DW-1], in_r};
    assign sum_i = {d_i[DW-1], d_i} + {in_i[DW-1], in_i};
    assign dif_r = {d_r[DW-1], d_r} - {in_r[DW-1], in_r};
    assign dif_i = {d_i[DW-1], d_i} - {in_i[DW-1], in_i};

    assign tw_fill = TW_W'(int'(cnt_q) * TW_STRIDE);

    always_comb begin
        cnt_d       = cnt_q;
        primed_d    = primed_q;
        out_valid_d = 1'b0;
        out_sof_d   = out_sof_q;
        out_r_d     = out_r_q;
        out_i_d     = out_i_q;
        tw_d        = tw_q;
        dl_din      = {in_r, in_i};
        if (in_valid) begin
            cnt_d = cnt_q + CW'(1);
            if (stage == FILL) begin
                // Previous block's differences drain out while the new half fills.
                out_r_d     = d_r;
                out_i_d     = d_i;
                tw_d        = tw_fill;
                out_sof_d   = 1'b0;
                out_valid_d = primed_q;
            end else begin
                out_r_d     = rescale(sum_r);
                out_i_d     = rescale(sum_i);
                dl_din      = {rescale(dif_r), rescale(dif_i)};
                tw_d        = '0;
                out_sof_d   = (cnt_q == CW'(DELAY));
                out_valid_d = 1'b1;
                primed_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_r_q     <= '0;
            out_i_q     <= '0;
            tw_q        <= '0;
        end else begin
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_r_q     <= out_r_d;
            out_i_q     <= out_i_d;
            tw_q        <= tw_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_r     = out_r_q;
    assign out_i     = out_i_q;
    assign tw_idx    = tw_q;

endmodule

// File: tb/tb_sdf_butterfly_stage.sv
// Directed bench for sdf_butterfly_stage across five DELAY/SCALE configurations.
module tb_sdf_butterfly_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_r, in_i;

    logic        ov   [5];
    logic        osof [5];
    logic [15:0] orr  [5];
    logic [15:0] oi   [5];
    logic [4:0]  otw  [5];

    int          sel;
    logic        obs_valid, obs_sof;
    logic [15:0] obs_r, obs_i;
    logic [4:0]  obs_tw;
    logic [38:0] obs_all;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        sof;
        logic [4:0]  tw;
        logic [15:0] r;
        logic [15:0] i;
    } exp_t;

    exp_t        expq [$];
    logic [15:0] stim_r [$];
    logic [15:0] stim_i [$];

    always #5 clk = ~clk;

    sdf_butterfly_stage #(.DELAY(2), .TW_STRIDE(1), .SCALE(1)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
        .out_valid(ov[0]), .out_r(orr[0]), .out_i(oi[0]), .tw_idx(otw[0]), .out_sof(osof[0]));

    sdf_butterfly_stage #(.DELAY(1), .TW_STRIDE(32), .SCALE(0)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
        .out_valid(ov[1]), .out_r(orr[1]), .out_i(oi[1]), .tw_idx(otw[1]), .out_sof(osof[1]));

    sdf_butterfly_stage #(.DELAY(8), .TW_STRIDE(4), .SCALE(1)) u_d8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
        .out_valid(ov[2]), .out_r(orr[2]), .out_i(oi[2]), .tw_idx(otw[2]), .out_sof(osof[2]));

    sdf_butterfly_stage #(.DELAY(4), .TW_STRIDE(8), .SCALE(1)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
        .out_valid(ov[3]), .out_r(orr[3]), .out_i(oi[3]), .tw_idx(otw[3]), .out_sof(osof[3]));

    sdf_butterfly_stage #(.DELAY(32), .TW_STRIDE(1), .SCALE(1)) u_d32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
        .out_valid(ov[4]), .out_r(orr[4]), .out_i(oi[4]), .tw_idx(otw[4]), .out_sof(osof[4]));

    always_comb begin
        obs_valid = ov[0]; obs_sof = osof[0]; obs_r = orr[0]; obs_i = oi[0]; obs_tw = otw[0];
        case (sel)
            1: begin obs_valid = ov[1]; obs_sof = osof[1]; obs_r = orr[1]; obs_i = oi[1]; obs_tw = otw[1]; end
            2: begin obs_valid = ov[2]; obs_sof = osof[2]; obs_r = orr[2]; obs_i = oi[2]; obs_tw = otw[2]; end
            3: begin obs_valid = ov[3]; obs_sof = osof[3]; obs_r = orr[3]; obs_i = oi[3]; obs_tw = otw[3]; end
            4: begin obs_valid = ov[4]; obs_sof = osof[4]; obs_r = orr[4]; obs_i = oi[4]; obs_tw = otw[4]; end
            default: ;
        endcase
    end

    assign obs_all = {obs_valid, obs_sof, obs_tw, obs_r, obs_i};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] r, input logic [15:0] i);
        @(negedge clk);
        in_valid = v;
        in_r     = r;
        in_i     = i;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [15:0] bf(input logic [15:0] a, input logic [15:0] b,
                                       input bit sub, input bit scale);
        int s;
        s = sub ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
        if (scale) s = s >>> 1;
        return 16'(s);
    endfunction

    function automatic exp_t mk(input logic sof, input logic [4:0] tw,
                                input logic [15:0] r, input logic [15:0] i);
        exp_t e;
        e.sof = sof; e.tw = tw; e.r = r; e.i = i;
        return e;
    endfunction

    // Block view: block b's sums come out in its second half, its differences
    // (with twiddle c*stride) in the first half of block b+1; block 0's first half is silent.
    task automatic build_exp(input int D, input int stride, input bit scale);
        int blk, c, base;
        expq.delete();
        for (int p = 0; p < stim_r.size(); p++) begin
            blk = p / (2 * D);
            c   = p % (2 * D);
            if (c < D) begin
                if (blk > 0) begin
                    base = (blk - 1) * 2 * D;
                    expq.push_back(mk(1'b0, 5'((c * stride) % 32),
                        bf(stim_r[base + c], stim_r[base + c + D], 1'b1, scale),
                        bf(stim_i[base + c], stim_i[base + c + D], 1'b1, scale)));
                end
            end else begin
                base = blk * 2 * D;
                expq.push_back(mk(c == D, 5'd0,
                    bf(stim_r[base + c - D], stim_r[p], 1'b0, scale),
                    bf(stim_i[base + c - D], stim_i[p], 1'b0, scale)));
            end
        end
    endtask

    task automatic run_stream(input bit gaps, input string tag, output int sofs);
        int k;
        k    = 0;
        sofs = 0;
        for (int p = 0; p < stim_r.size(); p++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    step(1'b0, 16'h0, 16'h0);
                    chk({tag, "_idle_valid"}, 64'(obs_valid), 64'(0));
                end
            end
            step(1'b1, stim_r[p], stim_i[p]);
            if (obs_valid) begin
                if (k < expq.size())
                    chk({tag, "_out"}, 64'({obs_sof, obs_tw, obs_r, obs_i}),
                        64'({expq[k].sof, expq[k].tw, expq[k].r, expq[k].i}));
                k++;
                if (obs_sof) sofs++;
            end
        end
        chk({tag, "_count"}, 64'(k), 64'(expq.size()));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int sofs;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_r     = '0;
        in_i     = '0;
        sel      = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 5; s++) begin
            sel = s;
            #1;
            chk("reset_outputs", 64'(obs_all), 64'(0));
        end
        @(negedge clk);
        rst = 1'b0;

        // Basic butterfly, DELAY=2
        sel = 0;
        step(1'b1, 16'h0100, 16'h0010); chk("t1_fill0_valid", 64'(obs_valid), 64'(0));
        step(1'b1, 16'h0200, 16'h0000); chk("t1_fill1_valid", 64'(obs_valid), 64'(0));
        step(1'b1, 16'h0300, 16'h0000); chk("t1_sum0", 64'(obs_all), 64'({1'b1, 1'b1, 5'd0, 16'h0200, 16'h0008}));
        step(1'b1, 16'h0400, 16'h0000); chk("t1_sum1", 64'(obs_all), 64'({1'b1, 1'b0, 5'd0, 16'h0300, 16'h0000}));
        step(1'b1, 16'h0000, 16'h0000); chk("t1_dif0", 64'(obs_all), 64'({1'b1, 1'b0, 5'd0, 16'hFF00, 16'h0008}));
        step(1'b1, 16'h0000, 16'h0000); chk("t1_dif1", 64'(obs_all), 64'({1'b1, 1'b0, 5'd1, 16'hFF00, 16'h0000}));

        // Gapped input, same vectors
        do_reset();
        stim_r = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0000, 16'h0000};
        stim_i = '{16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        expq.delete();
        expq.push_back(mk(1'b1, 5'd0, 16'h0200, 16'h0008));
        expq.push_back(mk(1'b0, 5'd0, 16'h0300, 16'h0000));
        expq.push_back(mk(1'b0, 5'd0, 16'hFF00, 16'h0008));
        expq.push_back(mk(1'b0, 5'd1, 16'hFF00, 16'h0000));
        run_stream(1'b1, "t2", sofs);

        // Unscaled wrap, DELAY=1
        sel = 1;
        do_reset();
        step(1'b1, 16'h7F00, 16'h0000); chk("t3_fill_valid", 64'(obs_valid), 64'(0));
        step(1'b1, 16'h0200, 16'h0000); chk("t3_sum_wrap", 64'(obs_all), 64'({1'b1, 1'b1, 5'd0, 16'h8100, 16'h0000}));
        step(1'b1, 16'h0000, 16'h0000); chk("t3_dif", 64'(obs_all), 64'({1'b1, 1'b0, 5'd0, 16'h7D00, 16'h0000}));

        // Twiddle stride, DELAY=8 TW_STRIDE=4
        sel = 2;
        do_reset();
        stim_r.delete();
        stim_i.delete();
        for (int n = 0; n < 40; n++) begin
            stim_r.push_back(n < 32 ? 16'($urandom) : 16'h0);
            stim_i.push_back(n < 32 ? 16'($urandom) : 16'h0);
        end
        build_exp(8, 4, 1'b1);
        run_stream(1'b0, "t4", sofs);
        chk("t4_sof_count", 64'(sofs), 64'(2));

        // Mid-block reset, DELAY=4; the reset cycle also carries a sample that must be dropped
        sel = 3;
        do_reset();
        step(1'b1, 16'h1000, 16'h0);
        step(1'b1, 16'h2000, 16'h0);
        step(1'b1, 16'h3000, 16'h0);
        step(1'b1, 16'h4000, 16'h0);
        step(1'b1, 16'h5000, 16'h0);
        chk("t5_pre_sum", 64'(obs_all), 64'({1'b1, 1'b1, 5'd0, 16'h3000, 16'h0000}));
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_r     = 16'h7777;
        in_i     = 16'h1111;
        @(posedge clk);
        #1;
        chk("t5_after_reset", 64'(obs_all), 64'(0));
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        stim_r = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600,
                   16'h0700, 16'h0800, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        stim_i = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                   16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        expq.delete();
        expq.push_back(mk(1'b1, 5'd0,  16'h0300, 16'h0));
        expq.push_back(mk(1'b0, 5'd0,  16'h0400, 16'h0));
        expq.push_back(mk(1'b0, 5'd0,  16'h0500, 16'h0));
        expq.push_back(mk(1'b0, 5'd0,  16'h0600, 16'h0));
        expq.push_back(mk(1'b0, 5'd0,  16'hFE00, 16'h0));
        expq.push_back(mk(1'b0, 5'd8,  16'hFE00, 16'h0));
        expq.push_back(mk(1'b0, 5'd16, 16'hFE00, 16'h0));
        expq.push_back(mk(1'b0, 5'd24, 16'hFE00, 16'h0));
        run_stream(1'b0, "t5", sofs);

        // Full-size, DELAY=32: 3 blocks plus drain
        sel = 4;
        do_reset();
        stim_r.delete();
        stim_i.delete();
        for (int n = 0; n < 224; n++) begin
            stim_r.push_back(n < 192 ? 16'($urandom) : 16'h0);
            stim_i.push_back(n < 192 ? 16'($urandom) : 16'h0);
        end
        build_exp(32, 1, 1'b1);
        chk("t6_model_len", 64'(expq.size()), 64'(192));
        run_stream(1'b0, "t6", sofs);
        chk("t6_sof_count", 64'(sofs), 64'(3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdf_butterfly_stage.md
# sdf_butterfly_stage

Radix-2 decimation-in-frequency single-path delay-feedback (SDF) butterfly stage for the 64-point streaming FFT. It sits directly upstream of the complex multiplier. It delivers one butterfly output per accepted input sample, with a matching twiddle ROM index, so the multiplier can rotate the difference half of each block. One instance is used per FFT stage, configured by `DELAY`: 32, 16, 8, 4, 2, 1.

## Interface
- `INTEGER_SIZE`, 8, integer bits of the signed fixed-point sample.
- `FRACT_SIZE`, 8, fractional bits. `DATA_WIDTH = INTEGER_SIZE+FRACT_SIZE`.
- `DELAY`, 32, feedback depth in samples. Must be a power of two, ≥1. Block length is `2*DELAY`.
- `TW_W`, 5, twiddle index width, i.e. log2(N/2) for N=64.
- `TW_STRIDE`, 1, index multiplier, equal to `64/(2*DELAY)`.
- `SCALE`, 1. 1 gives sum/difference arithmetic-shifted right by 1; 0 gives unscaled, wrapped results.
- `clk`  in  1  single clock. All logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  sample-present strobe. There is no backpressure.
- `in_r`, `in_i`  in  DATA_WIDTH each  signed input sample.
- `out_valid`  out  1  output-present strobe.
- `out_r`, `out_i`  out  DATA_WIDTH each  signed butterfly output.
- `tw_idx`  out  TW_W  twiddle ROM address aligned with the output. It is 0 for sum outputs.
- `out_sof`  out  1  high with the first sum output of each block.

## Operation
- Sample counter `cnt` is log2(2*DELAY) bits. It advances only on `in_valid` and wraps at `2*DELAY-1` → 0.
- The delay line (`DELAY` complex entries) shifts only on `in_valid`. Let `d` = delay line output.
- **FILL** (`cnt < DELAY`):
  - Write the input into the delay line.
  - Output `d`, which is the stored difference from the previous block.
  - `tw_idx = cnt*TW_STRIDE`, truncated to TW_W.
- **BFLY** (`cnt ≥ DELAY`):
  - Output `(d + in)`. Write `(d − in)` into the delay line.
  - `tw_idx = 0`.
  - `out_sof` is high when `cnt == DELAY`.
- Arithmetic:
  - Sum and difference are computed at DATA_WIDTH+1 bits.
  - SCALE=1: arithmetic shift right by 1 (floor), then take the low DATA_WIDTH bits.
  - SCALE=0: take the low DATA_WIDTH bits (two's-complement wrap).
  - The shift is applied before storing the difference.
- `primed` flag:
  - Cleared by reset. Set on the first accepted BFLY sample.
  - FILL outputs are suppressed (`out_valid=0`) while `primed=0`. BFLY outputs are always valid.
- The last block's differences emerge only when the next block is fed. Draining requires feeding `DELAY` further samples (zeros are acceptable).

## Timing
- Latency is 1 cycle. A sample accepted at edge k produces `out_*`, `tw_idx`, `out_sof` and `out_valid` registered at edge k.
- Cycles with `in_valid=0`: `out_valid=0`, other outputs hold, and `cnt` and the delay line freeze.
- Reset values:
  - `out_valid=0`, `out_sof=0`, `out_r=out_i=0`, `tw_idx=0`.
  - `cnt=0`, `primed=0`, all delay entries 0.
- Reset asserted mid-block discards all stored data. The first sample after reset is `cnt=0` (FILL), with its output suppressed.
- If `rst` and `in_valid` are both high, reset wins and the sample is dropped.
- DELAY=1 is legal: FILL/BFLY alternate every sample.
- The downstream complex multiplier has 2-cycle latency. It consumes `out_*` and `tw_idx` together, so the twiddle ROM must be registered identically to stay aligned.

## Structure
- Shared package `fft_pkg`:
  - FFT size constant (64).
  - `DATA_WIDTH` derivation.
  - clog2 helper.
  - `stage_e` enum {FILL, BFLY}.
- Sub-module `sdf_delay_line`:
  - Parameters `WIDTH = 2*DATA_WIDTH` and `DEPTH = DELAY`.
  - Ports `clk`, `rst`, `en`, `din`, `dout`.
  - Implemented as a circular buffer with a read/write pointer, with a register fallback for DEPTH=1.
- The butterfly adder/shift logic is inline in the stage.

## Test plan
- **Basic butterfly.** DELAY=2, SCALE=1, Q8.8. Feed real samples 0x0100, 0x0200, 0x0300, 0x0400, then 0, 0.
  - Required valid outputs, in order: 0x0200 (sof=1), 0x0300, 0xFF00 (tw 0), 0xFF00 (tw 1).
  - No valid output during the first two FILL samples.
- **Gapped input.** Same stimulus with `in_valid` gapped at random (0–3 idle cycles).
  - Identical output sequence. `out_valid` is never high on an idle cycle.
- **Unscaled wrap.** SCALE=0, DELAY=1. Inputs 0x7F00 then 0x0200.
  - Sum wraps to 0x8100.
  - Difference 0x7D00 appears on the next FILL output, with tw_idx 0.
- **Twiddle stride.** DELAY=8, TW_STRIDE=4. Feed 32 random samples plus 8 zeros.
  - FILL outputs carry tw_idx 0,4,8,…,28.
  - Values match a bit-exact model.
- **Mid-block reset.** Pulse `rst` at cnt=5, DELAY=4.
  - Next cycle: all outputs 0.
  - The next 4 samples produce no valid output.
  - Sums start on the 5th sample, with the old data absent from the outputs.
- **Full-size config.** DELAY=32. Stream 3 random 64-sample blocks plus 32 zeros and compare against the model.
  - Exactly 96 sum and 96 difference outputs.
  - `out_sof` pulses 3 times.
